// File: rtl/sp_ram.sv
// ============================================================================
// Module   : sp_ram
// Brief    : Synchronous single-port RAM with one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram #(
    parameter int WD = 8,
    parameter int AD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        w_r_n,
    input  logic [AD:1] addr,
    input  logic [WD:1] din,
    output logic [WD:1] dout
);

    localparam int c_depth = 2 ** AD;

    // The array name and shape must stay fixed so hierarchical preloads can reach it.
    logic [WD:1] buffer [0:c_depth-1];

    logic w_wr_en;
    logic w_rd_en;

    // An X/Z on either control bit makes these false, so nothing is written.
    assign w_wr_en = (cs_n == 1'b0) && (w_r_n == 1'b1);
    assign w_rd_en = (cs_n == 1'b0) && (w_r_n == 1'b0);

    // Storage has no reset, so preloaded contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            buffer[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (w_rd_en) begin
            dout <= buffer[addr];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sp_ram.sv
// ============================================================================
// Module   : tb_sp_ram
// Brief    : Directed self-checking bench for sp_ram.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sp_ram;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       w_r_n;
    logic [4:1] addr;
    logic [8:1] din;
    logic [8:1] dout;

    int n_total;
    int n_pass;

    sp_ram #(.WD(8), .AD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs_n  (cs_n),
        .w_r_n (w_r_n),
        .addr  (addr),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        // Reset held from time 0 with a write request pending.
        rst_n = 1'b0;
        cs_n  = 1'b0;
        w_r_n = 1'b1;
        addr  = 4'd9;
        din   = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            dut.buffer[i] = 8'h10 + 8'(i);
        end

        tick();
        tick();
        tick();
        check("reset_dout", dout, 8'h00);

        cs_n  = 1'b1;
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", dout, 8'h00);

        cs_n  = 1'b0;
        w_r_n = 1'b0;
        addr  = 4'd9;
        tick();
        check("no_write_in_reset", dout, 8'h19);

        // Preloaded contents read back with one-cycle latency.
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            check($sformatf("preload_rd_%0d", i), dout, 8'h10 + 8'(i));
        end

        // Write burst; dout must keep the last read value.
        w_r_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            din  = 8'hA0 + 8'(i);
            tick();
            check($sformatf("wr_hold_%0d", i), dout, 8'h1F);
        end

        w_r_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            check($sformatf("wr_rd_%0d", i), dout, 8'hA0 + 8'(i));
        end

        // Idle with a would-be write on the bus.
        cs_n  = 1'b1;
        w_r_n = 1'b1;
        addr  = 4'd3;
        din   = 8'h55;
        for (int i = 0; i < 4; i++) tick();
        check("idle_hold", dout, 8'hAF);

        cs_n  = 1'b0;
        w_r_n = 1'b0;
        addr  = 4'd3;
        tick();
        check("idle_no_write", dout, 8'hA3);

        // Asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dout, 8'h00);
        rst_n = 1'b1;
        addr  = 4'd5;
        tick();
        check("mem_retained", dout, 8'hA5);

        // Back-to-back write then read of the same address.
        w_r_n = 1'b1;
        addr  = 4'd7;
        din   = 8'hC7;
        tick();
        check("b2b_wr_hold", dout, 8'hA5);
        w_r_n = 1'b0;
        tick();
        check("b2b_rd", dout, 8'hC7);
        addr = 4'd15;
        tick();
        check("top_addr", dout, 8'hAF);

        // Unknown access type must not write.
        w_r_n = 1'bx;
        addr  = 4'd2;
        din   = 8'h77;
        tick();
        w_r_n = 1'b0;
        tick();
        check("x_ctrl_no_write", dout, 8'hA2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
